irq_request_latch: RTL

- Upstream stage of the 8-to-3 priority encoder in the interrupt path.
- Captures rising edges on 8 request lines into a pending register and applies a programmable mask. Drives the masked pending vector to the encoder's `a` input.
- Registers the encoder's `out`/`valid` result into a request/acknowledge offer to the consumer. On acknowledge, clears the serviced pending bit.
- The encoder is external and combinational: pend_out feeds it, and its result returns on enc_idx/enc_valid.

---
 rtl/irq_pkg.sv | 11 +
 rtl/irq_edge_detect.sv | 40 ++++
 rtl/irq_request_latch.sv | 93 +++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the interrupt request latch.
package irq_pkg;
    localparam int unsigned N_IRQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam logic [N_IRQ-1:0] MASK_RST = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_state_e;
endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the raw request lines.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of edge detect.
module irq_edge_detect #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] irq_i,
    output logic [W-1:0] edge_o
);
    logic [W-1:0] irq_s;
    logic [W-1:0] irq_q;

`ifdef IRQ_SYNC_EN
    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;

    // Two-stage synchronizer for asynchronous request lines
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    // One-cycle history so a held level yields a single edge
    always_ff @(posedge clk) begin
        if (rst) irq_q <= '0;
        else     irq_q <= irq_s;
    end

    assign edge_o = irq_s & ~irq_q;
endmodule

// File: rtl/irq_request_latch.sv
// Interrupt request latch: captures request edges into a pending register,
// masks them toward an external priority encoder, and turns the encoder's
// result into a held request/acknowledge offer.
// Optional macro IRQ_SYNC_EN adds a 2-flop input synchronizer (2 cycles extra).
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int unsigned       P_N_IRQ    = N_IRQ,
    parameter int unsigned       P_IDX_W    = IDX_W,
    parameter logic [P_N_IRQ-1:0] P_MASK_RST = MASK_RST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_N_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [P_N_IRQ-1:0] mask_in,
    output logic [P_N_IRQ-1:0] pend_out,
    input  logic [P_IDX_W-1:0] enc_idx,
    input  logic               enc_valid,
    output logic               req_valid,
    output logic [P_IDX_W-1:0] req_idx,
    input  logic               ack,
    output logic               overflow,
    input  logic               ovf_clr
);
    irq_state_e         state_q;
    logic [P_N_IRQ-1:0] pend_q, pend_d;
    logic [P_N_IRQ-1:0] mask_q;
    logic [P_N_IRQ-1:0] edge_v;
    logic [P_N_IRQ-1:0] clr_vec;
    logic               ovf_q, ovf_d;
    logic               req_valid_q;
    logic [P_IDX_W-1:0] req_idx_q;

    irq_edge_detect #(.W(P_N_IRQ)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .irq_i  (irq_in),
        .edge_o (edge_v)
    );

    // Pending/overflow next state; a new edge beats a same-cycle clear
    always_comb begin
        clr_vec = '0;
        if (state_q == OFFER && ack) clr_vec[req_idx_q] = 1'b1;
        pend_d = (pend_q & ~clr_vec) | edge_v;
        ovf_d  = (ovf_q & ~ovf_clr) | (|(edge_v & pend_q & ~clr_vec));
    end

    // Pending, mask and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= P_MASK_RST;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            if (mask_wr) mask_q <= mask_in;
        end
    end

    // Offer FSM: latch the encoder result and hold it until acknowledged
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_valid) begin
                        req_idx_q   <= enc_idx;
                        req_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (ack) begin
                        req_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pend_out  = pend_q & mask_q;
    assign req_valid = req_valid_q;
    assign req_idx   = req_idx_q;
    assign overflow  = ovf_q;
endmodule
